// File: rtl/vic_pot_pkg.sv
// Shared types and constants for the VIC POTX/POTY measurement path.
package vic_pot_pkg;

  typedef enum logic {
    POT_DISCHARGE = 1'b0,
    POT_CHARGE    = 1'b1
  } pot_phase_t;

  localparam int unsigned POT_CHARGE_TICKS = 256;
  localparam int unsigned POT_CNT_W        = 9;
  localparam int unsigned POT_VAL_W        = 8;
  localparam logic [POT_VAL_W-1:0] POT_OPEN_VALUE = 8'hFF;

endpackage

// File: rtl/pot_channel.sv
// One pot line: target snapshot, threshold-crossing capture and CPU-visible latch.
module pot_channel
  import vic_pot_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 snapshot_i,
  input  logic                 measure_i,
  input  logic                 transfer_i,
  input  logic                 connected_i,
  input  logic [POT_VAL_W-1:0] k_i,
  input  logic [POT_VAL_W-1:0] target_i,
  output logic [POT_VAL_W-1:0] value_o
);

  logic [POT_VAL_W-1:0] target_q, target_d;
  logic [POT_VAL_W-1:0] capture_q, capture_d;
  logic [POT_VAL_W-1:0] value_q, value_d;
  logic                 crossed_q, crossed_d;
  logic                 hit_c;

  // Connection is sampled live; a line that drops before crossing stays open.
  assign hit_c = measure_i && !crossed_q && connected_i && (k_i >= target_q);

  always_comb begin
    target_d  = target_q;
    capture_d = capture_q;
    crossed_d = crossed_q;
    value_d   = value_q;
    if (ce) begin
      if (snapshot_i) begin
        target_d  = target_i;
        crossed_d = 1'b0;
      end else if (hit_c) begin
        crossed_d = 1'b1;
        capture_d = k_i;
      end
      // A crossing on the final tick is folded into the same transfer.
      if (transfer_i) begin
        if (crossed_q)  value_d = capture_q;
        else if (hit_c) value_d = k_i;
        else            value_d = POT_OPEN_VALUE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q  <= '0;
      capture_q <= '0;
      crossed_q <= 1'b0;
      value_q   <= POT_OPEN_VALUE;
    end else begin
      target_q  <= target_d;
      capture_q <= capture_d;
      crossed_q <= crossed_d;
      value_q   <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/vic_pot_adc.sv
// VIC 6560/6561 POTX/POTY emulation: free-running discharge/charge cycle feeding two pot channels.
module vic_pot_adc
  import vic_pot_pkg::*;
#(
  parameter int unsigned DISCHARGE_TICKS = 256,
  parameter int unsigned CHARGE_TICKS    = POT_CHARGE_TICKS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [1:0][POT_VAL_W-1:0] pot_in,
  input  logic [1:0]                pot_connected,
  output logic [1:0][POT_VAL_W-1:0] pot_value,
  output logic                      pot_valid,
  output logic                      pot_dump,
  output logic                      charging
);

  pot_phase_t           state_q, state_d;
  logic [POT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 pot_valid_q, pot_valid_d;
  logic                 pot_dump_q, pot_dump_d;
  logic                 charging_q, charging_d;
  logic                 snapshot_c;
  logic                 transfer_c;
  logic                 measure_c;

  // Phase sequencing; the counter restarts on every phase entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pot_valid_d = 1'b0;
    snapshot_c  = 1'b0;
    transfer_c  = 1'b0;
    if (ce) begin
      case (state_q)
        POT_DISCHARGE: begin
          if (cnt_q == POT_CNT_W'(DISCHARGE_TICKS - 1)) begin
            state_d    = POT_CHARGE;
            cnt_d      = '0;
            snapshot_c = 1'b1;
          end else begin
            cnt_d = cnt_q + POT_CNT_W'(1);
          end
        end
        POT_CHARGE: begin
          if (cnt_q == POT_CNT_W'(CHARGE_TICKS - 1)) begin
            state_d     = POT_DISCHARGE;
            cnt_d       = '0;
            transfer_c  = 1'b1;
            pot_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + POT_CNT_W'(1);
          end
        end
      endcase
    end
    pot_dump_d = (state_d == POT_DISCHARGE);
    charging_d = (state_d == POT_CHARGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= POT_DISCHARGE;
      cnt_q       <= '0;
      pot_valid_q <= 1'b0;
      pot_dump_q  <= 1'b1;
      charging_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pot_valid_q <= pot_valid_d;
      pot_dump_q  <= pot_dump_d;
      charging_q  <= charging_d;
    end
  end

  assign measure_c = (state_q == POT_CHARGE);

  pot_channel u_chan_x (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .snapshot_i  (snapshot_c),
    .measure_i   (measure_c),
    .transfer_i  (transfer_c),
    .connected_i (pot_connected[0]),
    .k_i         (cnt_q[POT_VAL_W-1:0]),
    .target_i    (pot_in[0]),
    .value_o     (pot_value[0])
  );

  pot_channel u_chan_y (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .snapshot_i  (snapshot_c),
    .measure_i   (measure_c),
    .transfer_i  (transfer_c),
    .connected_i (pot_connected[1]),
    .k_i         (cnt_q[POT_VAL_W-1:0]),
    .target_i    (pot_in[1]),
    .value_o     (pot_value[1])
  );

  assign pot_valid = pot_valid_q;
  assign pot_dump  = pot_dump_q;
  assign charging  = charging_q;

endmodule
